ball_engine: RTL and testbench
==============================

// Module: ball_engine
// PURPOSE
//  Ball motion and scoring engine for the 64x32 (x by y) playfield. Steps the ball once per game tick
//  and bounces it off the top and bottom walls. Drives the ball row and per-side range strobes
//  into the left and right paddle blocks, then consumes their hit results. Keeps score, serves
//  after each point and freezes the game at the win score.
// PARAMETERS
//  TICK_DIV      2500000  clk cycles per ball step (>=2)
//  MIN_TICK_DIV  625000   floor on the step period; used only with BALL_SPEEDUP_EN
//  WIN_SCORE     9        points needed to win (1..15)
// PORTS
//  clk          in   1  system clock; all state changes on posedge clk
//  reset        in   1  asynchronous, active-low reset
//  start        in   1  1-cycle pulse; serves the ball (SERVE) or restarts the match (GAME_OVER)
//  hit_l        in   1  left paddle hit result; valid the cycle after in_range_l
//  hit_r        in   1  right paddle hit result; valid the cycle after in_range_r
//  ball_x       out  6  ball column 0..63
//  ball_y       out  5  ball row 0..31; goes to the paddle ballPosition inputs
//  in_range_l   out  1  1-cycle strobe; ball is at x=1 and moving left
//  in_range_r   out  1  1-cycle strobe; ball is at x=62 and moving right
//  score_l      out  4  left player score
//  score_r      out  4  right player score
//  point_l      out  1  1-cycle pulse when the left player scores
//  point_r      out  1  1-cycle pulse when the right player scores
//  game_over    out  1  high while in GAME_OVER
// BEHAVIOUR
//  Reset values: ball_x=32, ball_y=16, dx=RIGHT, dy=DOWN(+1), scores=0, all strobes and pulses=0,
//   game_over=0, state=SERVE, tick counter=0, step period=TICK_DIV.
//  Tick: the counter runs 0..period-1 only in MOVE. tick=1 when the count wraps; the counter is
//   cleared on every entry to MOVE.
//  FSM:
//   SERVE: ball held at (32,16). start -> MOVE.
//   MOVE: on tick, x+=dx. If y=31 and dy=DOWN, set dy=UP and y=30. If y=0 and dy=UP, set dy=DOWN
//    and y=1. Otherwise y+=dy. After the step, if (x=1,dx=LEFT) or (x=62,dx=RIGHT), go to CHECK.
//   CHECK: exactly 1 cycle with the matching in_range_* high. No tick is counted.
//    Next cycle samples hit_*: hit=1 -> flip dx, back to MOVE; hit=0 -> go to SCORE.
//   SCORE: 1 cycle. The opponent's score increments and their point_* pulses.
//    Ball goes to (32,16) with dy=DOWN and dx toward the player who missed.
//    Next state: GAME_OVER if the new score = WIN_SCORE, else SERVE.
//   GAME_OVER: ball frozen, game_over=1. start -> scores cleared, dx=RIGHT, SERVE.
//  hit_l and hit_r are ignored outside the hit-sample cycle. start is ignored in MOVE, CHECK and SCORE.
//  Scores never exceed WIN_SCORE; there is no wrap.
//  Reset asserted mid-flight returns every register to its reset value immediately.
// CONFIGURATION
//  BALL_SPEEDUP_EN defined: each paddle hit sets
//   period = max(period - TICK_DIV/8, MIN_TICK_DIV). Every serve restores period=TICK_DIV.
//  Not defined: period is fixed at TICK_DIV and MIN_TICK_DIV is unused.
// STRUCTURE
//  Package pong_pkg holds:
//   FIELD_W=64, FIELD_H=32
//   SERVE_X=32, SERVE_Y=16
//   PADDLE_COL_L=1, PADDLE_COL_R=62
//   dir_t enum {LEFT/UP=0, RIGHT/DOWN=1}
//   ball_state_t enum {SERVE, MOVE, CHECK, SCORE, GAME_OVER}
//  Sub-module tick_gen (period register, counter, clear, tick output). All else stays in ball_engine.
// TESTING (TICK_DIV=4, MIN_TICK_DIV=2, WIN_SCORE=2 unless stated)
//  1. Reset low for 3 cycles, then release -> ball (32,16), scores 0/0, no strobes, game_over=0,
//     ball stays put without start.
//  2. start, hold hit_r=0 -> after 30 ticks ball is at (62,16). Along the way y peaks at 31 on
//     tick 15 and reads 30 on tick 16. in_range_r is high 1 cycle, then point_l pulses, score_l=1,
//     ball at (32,16), dx=RIGHT.
//  3. Repeat 2 with hit_r=1 in the sample cycle -> no point, dx=LEFT, next tick x=61.
//     in_range_l fires at x=1.
//  4. Two right-side misses -> score_l=2, game_over=1, ball frozen over 20 ticks. start ->
//     scores 0/0, SERVE.
//  5. Assert reset at x=45 mid-flight -> every output shows its reset value within the same
//     cycle; no point pulse.
//  6. With BALL_SPEEDUP_EN and TICK_DIV=16, MIN_TICK_DIV=8 -> step period 16,14,12,10,8,8 clk
//     after successive hits. A miss and re-serve restores 16.

Source files
------------

// File: rtl/pong_pkg.sv
// pong_pkg: shared playfield geometry, direction encoding and ball FSM states for the pong blocks.
package pong_pkg;
    localparam int FIELD_W      = 64;
    localparam int FIELD_H      = 32;
    localparam int XW           = $clog2(FIELD_W);
    localparam int YW           = $clog2(FIELD_H);
    localparam int SERVE_X      = 32;
    localparam int SERVE_Y      = 16;
    localparam int PADDLE_COL_L = 1;
    localparam int PADDLE_COL_R = 62;

    // One bit per axis: 0 means left/up, 1 means right/down.
    typedef enum logic {LEFT_UP = 1'b0, RIGHT_DOWN = 1'b1} dir_t;
    localparam dir_t LEFT  = LEFT_UP;
    localparam dir_t UP    = LEFT_UP;
    localparam dir_t RIGHT = RIGHT_DOWN;
    localparam dir_t DOWN  = RIGHT_DOWN;

    typedef enum logic [2:0] {SERVE, MOVE, CHECK, SCORE, GAME_OVER} ball_state_t;
endpackage

// File: rtl/ball_engine_tick_gen.sv
// tick_gen: ball step timer; counts only while enabled and holds zero otherwise.
// The period shrinks by STEP on each speedUp (floored at FLOOR) and returns to TICK_DIV on restore.
module tick_gen #(
    parameter int TICK_DIV = 4,
    parameter int FLOOR    = 2,
    parameter int STEP     = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic speedUp,
    input  logic restore,
    output logic tick
);
    localparam int CW = $clog2(TICK_DIV + 1);
    localparam logic [CW-1:0] DivV   = CW'(TICK_DIV);
    localparam logic [CW-1:0] FloorV = CW'(FLOOR);
    localparam logic [CW-1:0] StepV  = CW'(STEP);

    logic [CW-1:0] period;
    logic [CW-1:0] count;

    assign tick = en && (count == period - 1'b1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period <= DivV;
            count  <= '0;
        end else begin
            count <= (!en || tick) ? '0 : count + 1'b1;
            if (restore)
                period <= DivV;
            else if (speedUp)
                period <= (int'(period) < FLOOR + STEP) ? FloorV : period - StepV;
        end
    end
endmodule

// File: rtl/ball_engine.sv
// ball_engine: ball motion, wall bounce, paddle hand-off and scoring for the 64x32 playfield.
// Define BALL_SPEEDUP_EN to shorten the step period on every paddle hit (floor MIN_TICK_DIV).
module ball_engine
    import pong_pkg::*;
#(
    parameter int TICK_DIV     = 2500000,
    parameter int MIN_TICK_DIV = 625000,
    parameter int WIN_SCORE    = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          hit_l,
    input  logic          hit_r,
    output logic [XW-1:0] ball_x,
    output logic [YW-1:0] ball_y,
    output logic          in_range_l,
    output logic          in_range_r,
    output logic [3:0]    score_l,
    output logic [3:0]    score_r,
    output logic          point_l,
    output logic          point_r,
    output logic          game_over
);
`ifdef BALL_SPEEDUP_EN
    localparam int SpeedStep  = TICK_DIV / 8;
    localparam int SpeedFloor = MIN_TICK_DIV;
`else
    // A zero step leaves the period pinned at TICK_DIV.
    localparam int SpeedStep  = 0;
    localparam int SpeedFloor = (MIN_TICK_DIV < TICK_DIV) ? MIN_TICK_DIV : TICK_DIV;
`endif

    ball_state_t   state;
    dir_t          dx, dy;
    logic          sampleHit, tick, goingDown, atPaddle, hitNow, winNext;
    logic [XW-1:0] nextX;
    logic [YW-1:0] nextY;

    tick_gen #(.TICK_DIV(TICK_DIV), .FLOOR(SpeedFloor), .STEP(SpeedStep)) tickGen (
        .clk     (clk),
        .reset   (reset),
        .en      (state == MOVE),
        .speedUp (state == CHECK && sampleHit && hitNow),
        .restore (state == SCORE),
        .tick    (tick)
    );

    always_comb begin
        goingDown = (dy == DOWN) ^ ((ball_y == YW'(FIELD_H - 1) && dy == DOWN) || (ball_y == '0 && dy == UP));
        nextX     = (dx == RIGHT) ? ball_x + 1'b1 : ball_x - 1'b1;
        nextY     = goingDown ? ball_y + 1'b1 : ball_y - 1'b1;
        atPaddle  = (nextX == XW'(PADDLE_COL_L) && dx == LEFT) || (nextX == XW'(PADDLE_COL_R) && dx == RIGHT);
        hitNow    = (dx == LEFT) ? hit_l : hit_r;
        winNext   = (((dx == RIGHT) ? score_l : score_r) + 4'd1) == 4'(WIN_SCORE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= SERVE;
            ball_x     <= XW'(SERVE_X);
            ball_y     <= YW'(SERVE_Y);
            dx         <= RIGHT;
            dy         <= DOWN;
            score_l    <= '0;
            score_r    <= '0;
            in_range_l <= 1'b0;
            in_range_r <= 1'b0;
            point_l    <= 1'b0;
            point_r    <= 1'b0;
            game_over  <= 1'b0;
            sampleHit  <= 1'b0;
        end else begin
            point_l <= 1'b0;
            point_r <= 1'b0;
            case (state)
                SERVE: if (start) state <= MOVE;
                MOVE: if (tick) begin
                    ball_x <= nextX;
                    ball_y <= nextY;
                    dy     <= goingDown ? DOWN : UP;
                    if (atPaddle) begin
                        state      <= CHECK;
                        in_range_l <= (dx == LEFT);
                        in_range_r <= (dx == RIGHT);
                    end
                end
                // First CHECK cycle presents the strobe; the second samples the paddle's answer.
                CHECK: if (!sampleHit) begin
                    in_range_l <= 1'b0;
                    in_range_r <= 1'b0;
                    sampleHit  <= 1'b1;
                end else begin
                    sampleHit <= 1'b0;
                    state     <= hitNow ? MOVE : SCORE;
                    if (hitNow) dx <= dir_t'(~dx);
                end
                SCORE: begin
                    if (dx == RIGHT) begin
                        score_l <= score_l + 4'd1;
                        point_l <= 1'b1;
                    end else begin
                        score_r <= score_r + 4'd1;
                        point_r <= 1'b1;
                    end
                    ball_x    <= XW'(SERVE_X);
                    ball_y    <= YW'(SERVE_Y);
                    dy        <= DOWN;
                    state     <= winNext ? GAME_OVER : SERVE;
                    game_over <= winNext;
                end
                GAME_OVER: if (start) begin
                    score_l   <= '0;
                    score_r   <= '0;
                    dx        <= RIGHT;
                    game_over <= 1'b0;
                    state     <= SERVE;
                end
                default: state <= SERVE;
            endcase
        end
    end
endmodule

// File: tb/tb_ball_engine.sv
// tb_ball_engine: scoreboard bench for ball_engine; expected ball events are queued by the
// stimulus and consumed by a negedge monitor. Define BALL_SPEEDUP_EN to also check step periods.
module tb_ball_engine;
`ifdef BALL_SPEEDUP_EN
    localparam int TD  = 16;
    localparam int MTD = 8;
`else
    localparam int TD  = 4;
    localparam int MTD = 2;
`endif
    localparam int WIN = 2;
    localparam int STEP = 0, IRL = 1, IRR = 2, PTL = 3, PTR = 4;

    logic       clk = 1'b0, reset = 1'b0, start = 1'b0, hit_l = 1'b0, hit_r = 1'b0;
    logic [5:0] ball_x;
    logic [4:0] ball_y;
    logic       in_range_l, in_range_r, point_l, point_r, game_over;
    logic [3:0] score_l, score_r;

    typedef struct packed {int kind; int x; int y; int sl; int sr;} ev_t;
    ev_t expQ[$];
    int checks = 0, failures = 0, cyc = 0, u = 0;
    logic monEn = 1'b1, planL = 1'b0, planR = 1'b0, lastL = 1'b0, lastR = 1'b0;
    logic [10:0] prevPos = '0;

    ball_engine #(.TICK_DIV(TD), .MIN_TICK_DIV(MTD), .WIN_SCORE(WIN)) dut (
        .clk(clk), .reset(reset), .start(start), .hit_l(hit_l), .hit_r(hit_r),
        .ball_x(ball_x), .ball_y(ball_y), .in_range_l(in_range_l), .in_range_r(in_range_r),
        .score_l(score_l), .score_r(score_r), .point_l(point_l), .point_r(point_r),
        .game_over(game_over)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic seen(input int kind);
        ev_t got, e;
        got = '{kind, int'(ball_x), int'(ball_y), int'(score_l), int'(score_r)};
        checks++;
        if (expQ.size() == 0) begin
            failures++;
            $display("FAIL event_unexpected actual kind=%0d x=%0d y=%0d sl=%0d sr=%0d required no event",
                     got.kind, got.x, got.y, got.sl, got.sr);
        end else begin
            e = expQ.pop_front();
            if (got != e) begin
                failures++;
                $display("FAIL event actual kind=%0d x=%0d y=%0d sl=%0d sr=%0d required kind=%0d x=%0d y=%0d sl=%0d sr=%0d",
                         got.kind, got.x, got.y, got.sl, got.sr, e.kind, e.x, e.y, e.sl, e.sr);
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset && monEn) begin
            if ({ball_x, ball_y} != prevPos) seen(STEP);
            if (in_range_l) seen(IRL);
            if (in_range_r) seen(IRR);
            if (point_l) seen(PTL);
            if (point_r) seen(PTR);
        end
        prevPos <= {ball_x, ball_y};
    end

    // Paddle stand-in: answers one cycle after the strobe, as a registered paddle would.
    initial forever begin
        @(negedge clk);
        hit_l = lastL & planL;
        hit_r = lastR & planR;
        lastL = in_range_l;
        lastR = in_range_r;
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    // Unfolded row coordinate reflected between rows 0 and 31.
    function automatic int fold(input int v);
        int m;
        m = ((v % 62) + 62) % 62;
        return (m <= 31) ? m : 62 - m;
    endfunction

    task automatic push(input int kind, input int x, input int y, input int sl, input int sr);
        expQ.push_back('{kind, x, y, sl, sr});
    endtask

    task automatic pushSteps(input int x0, input int dxs, input int n, input int sl, input int sr);
        for (int k = 1; k <= n; k++) begin
            u++;
            push(STEP, x0 + dxs * k, fold(u), sl, sr);
        end
    endtask

    task automatic drain(input string name, input int bound);
        for (int i = 0; i < bound && expQ.size() > 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk(name, expQ.size(), 0);
        expQ.delete();
    endtask

    task automatic pulseStart();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic measureGap(output int gap);
        logic [5:0] px;
        int t0;
        gap = -1;
        px = ball_x;
        for (int i = 0; i < 40 * TD && ball_x == px; i++) @(negedge clk);
        if (ball_x != px) begin
            t0 = cyc;
            px = ball_x;
            for (int i = 0; i < 4 * TD && ball_x == px; i++) @(negedge clk);
            if (ball_x != px) gap = cyc - t0;
        end
    endtask

    task automatic waitRange(input string name);
        for (int i = 0; i < 200 * TD && !(in_range_l || in_range_r); i++) @(negedge clk);
        chk(name, in_range_l | in_range_r, 1);
    endtask

    initial begin
        int gap;
        int speeds[6] = '{16, 14, 12, 10, 8, 8};
        // 1: reset and idle serve
        repeat (3) @(negedge clk);
        chk("rst_low_x", ball_x, 32);
        chk("rst_low_state_pt", {point_l, point_r, in_range_l, in_range_r, game_over}, 0);
        #1 reset = 1'b1;
        repeat (5 * TD) @(negedge clk);
        chk("rst_x", ball_x, 32);
        chk("rst_y", ball_y, 16);
        chk("rst_scores", {score_l, score_r}, 0);
        chk("rst_strobes", {in_range_l, in_range_r, point_l, point_r}, 0);
        chk("rst_game_over", game_over, 0);
        // 2: right player misses
        u = 16;
        pushSteps(32, 1, 30, 0, 0);
        push(IRR, 62, 16, 0, 0);
        push(STEP, 32, 16, 1, 0);
        push(PTL, 32, 16, 1, 0);
        pulseStart();
        drain("t2_drain", 100 * TD);
        chk("t2_score_l", score_l, 1);
        // 3: right hit, then left miss
        u = 16;
        pushSteps(32, 1, 30, 1, 0);
        push(IRR, 62, 16, 1, 0);
        pushSteps(62, -1, 61, 1, 0);
        push(IRL, 1, 17, 1, 0);
        push(STEP, 32, 16, 1, 1);
        push(PTR, 32, 16, 1, 1);
        planR = 1'b1;
        planL = 1'b0;
        pulseStart();
        drain("t3_drain", 300 * TD);
        chk("t3_score_r", score_r, 1);
        // 4: serve toward the left, left hits, right misses -> win
        u = 16;
        pushSteps(32, -1, 31, 1, 1);
        push(IRL, 1, 15, 1, 1);
        pushSteps(1, 1, 61, 1, 1);
        push(IRR, 62, 16, 1, 1);
        push(STEP, 32, 16, 2, 1);
        push(PTL, 32, 16, 2, 1);
        planL = 1'b1;
        planR = 1'b0;
        pulseStart();
        drain("t4_drain", 300 * TD);
        chk("t4_game_over", game_over, 1);
        repeat (20 * TD) @(negedge clk);
        chk("t4_frozen_xy", {ball_x, ball_y}, {6'd32, 5'd16});
        chk("t4_frozen_scores", {score_l, score_r}, {4'd2, 4'd1});
        chk("t4_still_over", game_over, 1);
        pulseStart();
        chk("t4_restart_scores", {score_l, score_r}, 0);
        chk("t4_restart_over", game_over, 0);
        repeat (3 * TD) @(negedge clk);
        chk("t4_serve_hold", {ball_x, ball_y}, {6'd32, 5'd16});
        chk("t4_queue", expQ.size(), 0);
        // 5: reset mid-flight at x=45
        planL = 1'b0;
        u = 16;
        pushSteps(32, 1, 13, 0, 0);
        pulseStart();
        for (int i = 0; i < 50 * TD && ball_x != 6'd45; i++) @(negedge clk);
        chk("t5_reach_x", ball_x, 45);
        #1 reset = 1'b0;
        #1;
        chk("t5_rst_xy", {ball_x, ball_y}, {6'd32, 5'd16});
        chk("t5_rst_scores", {score_l, score_r}, 0);
        chk("t5_rst_strobes", {in_range_l, in_range_r, point_l, point_r, game_over}, 0);
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        repeat (10 * TD) @(negedge clk);
        chk("t5_after_xy", {ball_x, ball_y}, {6'd32, 5'd16});
        chk("t5_queue", expQ.size(), 0);
`ifdef BALL_SPEEDUP_EN
        // 6: step period shrinks per hit and recovers on re-serve
        monEn = 1'b0;
        planL = 1'b1;
        planR = 1'b1;
        pulseStart();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) waitRange($sformatf("t6_range%0d", i));
            measureGap(gap);
            chk($sformatf("t6_period%0d", i), gap, speeds[i]);
        end
        planL = 1'b0;
        for (int i = 0; i < 200 * TD && !point_r; i++) @(negedge clk);
        chk("t6_point_r", point_r, 1);
        pulseStart();
        measureGap(gap);
        chk("t6_period_reserve", gap, 16);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
